// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and default widths.
// Optional instruction counter in pc_sequencer is enabled by PC_SEQ_INSTR_COUNT_EN.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_PC_INC     = 4;

endpackage

// File: rtl/pc_seq_drain_timer.sv
// Countdown used while the pipeline drains after a halt; done marks the last drain cycle.
module pc_seq_drain_timer #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic done
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= 4'(DRAIN_CYCLES);
    end else if (tick && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = tick && (count == 4'd1);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: run/step/drain/halt control plus next-PC selection.
// Define PC_SEQ_INSTR_COUNT_EN to build the retired-write counter on o_instr_count.
module pc_sequencer #(
  parameter int DATA_WIDTH   = pc_seq_pkg::DEFAULT_DATA_WIDTH,
  parameter int PC_INC       = pc_seq_pkg::DEFAULT_PC_INC,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_halt_instr,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_PC,
  input  logic                  i_branch_taken,
  input  logic [DATA_WIDTH-1:0] i_branch_target,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_jump_target,
  output logic [DATA_WIDTH-1:0] o_PC_next,
  output logic                  o_PC_write,
  output logic                  o_running,
  output logic                  o_halted,
  output logic [31:0]           o_instr_count
);

  import pc_seq_pkg::*;

  state_t state, state_next;
  logic   step_prev;
  logic   step_pending, step_pending_next;
  logic   step_rise;
  logic   drain_load, drain_tick, drain_done;

  assign step_rise = i_step && !step_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      step_prev    <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      state        <= state_next;
      step_prev    <= i_step;
      step_pending <= step_pending_next;
    end
  end

  // Halt always takes priority; a step request is only consumed once the stall clears.
  always_comb begin
    state_next        = state;
    step_pending_next = 1'b0;
    o_PC_write        = 1'b0;
    drain_load        = 1'b0;
    drain_tick        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_next = i_step_mode ? ST_STEP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_halt_instr) begin
          state_next = ST_DRAIN;
          drain_load = 1'b1;
        end else begin
          o_PC_write = !i_stall;
        end
      end
      ST_STEP: begin
        step_pending_next = step_pending;
        if (i_halt_instr) begin
          state_next        = ST_DRAIN;
          drain_load        = 1'b1;
          step_pending_next = 1'b0;
        end else if (step_pending && !i_stall) begin
          o_PC_write        = 1'b1;
          step_pending_next = 1'b0;
        end else if (step_rise && !step_pending) begin
          step_pending_next = 1'b1;
        end
      end
      ST_DRAIN: begin
        drain_tick = 1'b1;
        if (drain_done) begin
          state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (i_clear) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  pc_seq_drain_timer #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_drain_timer (
    .clk  (clk),
    .rst  (rst),
    .load (drain_load),
    .tick (drain_tick),
    .done (drain_done)
  );

  assign o_PC_next = i_jump         ? i_jump_target   :
                     i_branch_taken ? i_branch_target :
                                      i_PC + DATA_WIDTH'(PC_INC);

  assign o_running = (state == ST_RUN) || (state == ST_STEP);
  assign o_halted  = (state == ST_HALTED);

`ifdef PC_SEQ_INSTR_COUNT_EN
  logic [31:0] instr_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_count <= 32'd0;
    end else if ((state == ST_HALTED) && i_clear) begin
      instr_count <= 32'd0;
    end else if (o_PC_write) begin
      instr_count <= instr_count + 32'd1;
    end
  end

  assign o_instr_count = instr_count;
`else
  assign o_instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        i_start, i_step_mode, i_step, i_stall, i_halt_instr, i_clear;
  logic [31:0] i_PC, i_branch_target, i_jump_target;
  logic        i_branch_taken, i_jump;
  logic [31:0] o_PC_next;
  logic        o_PC_write, o_running, o_halted;
  logic [31:0] o_instr_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_count;

  pc_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_step_mode     (i_step_mode),
    .i_step          (i_step),
    .i_stall         (i_stall),
    .i_halt_instr    (i_halt_instr),
    .i_clear         (i_clear),
    .i_PC            (i_PC),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .o_PC_next       (o_PC_next),
    .o_PC_write      (o_PC_write),
    .o_running       (o_running),
    .o_halted        (o_halted),
    .o_instr_count   (o_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a rising edge; outputs are sampled at the falling edge.
  task automatic applyStimulus(input logic start, input logic step_mode, input logic step,
                               input logic stall, input logic halt, input logic clear);
    @(posedge clk);
    #1;
    i_start      = start;
    i_step_mode  = step_mode;
    i_step       = step;
    i_stall      = stall;
    i_halt_instr = halt;
    i_clear      = clear;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    i_start = 0; i_step_mode = 0; i_step = 0; i_stall = 0; i_halt_instr = 0; i_clear = 0;
    i_PC = 32'h100; i_branch_taken = 0; i_branch_target = 32'h40;
    i_jump = 0; i_jump_target = 32'h80;
`ifdef PC_SEQ_INSTR_COUNT_EN
    exp_count = 10;
`else
    exp_count = 0;
`endif

    #3;
    checkOutput("rst_running", o_running, 0);
    checkOutput("rst_pc_write", o_PC_write, 0);
    checkOutput("rst_halted", o_halted, 0);
    checkOutput("rst_count", o_instr_count, 0);
    checkOutput("rst_pc_next", o_PC_next, 32'h104);
    #9 rst = 1'b1;

    // Continuous run
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("idle_running", o_running, 0);
    checkOutput("idle_pc_write", o_PC_write, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("run_running", o_running, 1);
    checkOutput("run_pc_write", o_PC_write, 1);
    checkOutput("run_pc_next", o_PC_next, 32'h104);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("stall_pc_write", o_PC_write, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("unstall_pc_write", o_PC_write, 1);

    i_branch_taken = 1; i_jump = 1;
    #1 checkOutput("jump_over_branch", o_PC_next, 32'h80);
    i_jump = 0;
    #1 checkOutput("branch_target", o_PC_next, 32'h40);
    i_branch_taken = 0; i_PC = 32'hFFFF_FFFC;
    #1 checkOutput("pc_wrap", o_PC_next, 32'h0);
    i_PC = 32'h100;

    // Halt beats branch, then drain and halt
    i_branch_taken = 1;
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("halt_pc_write", o_PC_write, 0);
    checkOutput("halt_running", o_running, 1);
    i_branch_taken = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("drain_halted", o_halted, 0);
      checkOutput("drain_pc_write", o_PC_write, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("halted_flag", o_halted, 1);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("halted_ignores_start", o_halted, 1);
    checkOutput("halted_pc_write", o_PC_write, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("clear_cycle_halted", o_halted, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("cleared_halted", o_halted, 0);
    checkOutput("cleared_running", o_running, 0);
    checkOutput("cleared_count", o_instr_count, 0);

    // Step mode: held step gives one pulse
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("step_running", o_running, 1);
    checkOutput("step_idle_write", o_PC_write, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("step_edge_write", o_PC_write, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("step_pulse", o_PC_write, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("step_held_write", o_PC_write, 0);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("step_low_write", o_PC_write, 0);

    // Step edge while stalled defers the pulse
    applyStimulus(0, 1, 1, 1, 0, 0);
    checkOutput("stall_edge_write", o_PC_write, 0);
    applyStimulus(0, 1, 1, 1, 0, 0);
    checkOutput("stall_pending_write", o_PC_write, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("deferred_pulse", o_PC_write, 1);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("after_deferred_write", o_PC_write, 0);

    // Halt beats a pending step, then reset mid-drain
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 1, 0);
    checkOutput("halt_over_step", o_PC_write, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("mid_drain_running", o_running, 0);
    rst = 1'b0;
    #1;
    checkOutput("mid_drain_rst_halted", o_halted, 0);
    checkOutput("mid_drain_rst_running", o_running, 0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Fresh run: ten writes, then a full-length drain
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("count_run_write", o_PC_write, 1);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("instr_count", o_instr_count, 32'(exp_count));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("full_drain_halted", o_halted, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("full_drain_done", o_halted, 1);
    rst = 1'b0;
    #1;
    checkOutput("count_after_rst", o_instr_count, 0);
    checkOutput("halted_after_rst", o_halted, 0);
    @(posedge clk);
    #2 rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
